// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath geometry and the 20 operation codes.
// Used by alu_operand_stage, alu_regfile and the ALU itself.
package alu_pkg;

    localparam int DW   = 16;
    localparam int NREG = 8;
    localparam int AW   = 3;
    localparam int CW   = 5;

    localparam logic [CW-1:0] ALU_ADD   = 5'd0;
    localparam logic [CW-1:0] ALU_SUB   = 5'd1;
    localparam logic [CW-1:0] ALU_AND   = 5'd2;
    localparam logic [CW-1:0] ALU_OR    = 5'd3;
    localparam logic [CW-1:0] ALU_XOR   = 5'd4;
    localparam logic [CW-1:0] ALU_SLL   = 5'd5;
    localparam logic [CW-1:0] ALU_SRL   = 5'd6;
    localparam logic [CW-1:0] ALU_SRA   = 5'd7;
    localparam logic [CW-1:0] ALU_SLT   = 5'd8;
    localparam logic [CW-1:0] ALU_SLTU  = 5'd9;
    localparam logic [CW-1:0] ALU_MUL   = 5'd10;
    localparam logic [CW-1:0] ALU_MULH  = 5'd11;
    localparam logic [CW-1:0] ALU_MIN   = 5'd12;
    localparam logic [CW-1:0] ALU_MAX   = 5'd13;
    localparam logic [CW-1:0] ALU_MINU  = 5'd14;
    localparam logic [CW-1:0] ALU_MAXU  = 5'd15;
    localparam logic [CW-1:0] ALU_PASSA = 5'd16;
    localparam logic [CW-1:0] ALU_PASSB = 5'd17;
    localparam logic [CW-1:0] ALU_NOT   = 5'd18;
    localparam logic [CW-1:0] ALU_NEG   = 5'd19;

endpackage

// File: rtl/alu_regfile.sv
// NREG x DW register file: two operand read ports, one debug read port,
// one write port. r0 always reads 0 and ignores writes; sync active-low reset.
module alu_regfile #(
    parameter int DW   = alu_pkg::DW,
    parameter int NREG = alu_pkg::NREG,
    parameter int AW   = alu_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata
);

    logic [DW-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data  = (ra_addr  == '0) ? '0 : regs[ra_addr];
    assign rb_data  = (rb_addr  == '0) ? '0 : regs[rb_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch/issue stage: reads A/B from the register file, registers them
// toward the ALU, and writes the ALU result back one edge after issue.
// Ports: in_* upstream op (valid/ready), alu_* issued op and result alu_c,
// dbg_addr/dbg_data register peek, issue_cnt accepted-op counter.
// Build option: ALU_FWD_EN forwards alu_c on hazards instead of stalling.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int DW   = alu_pkg::DW,
    parameter int NREG = alu_pkg::NREG,
    parameter int AW   = alu_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_code,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic          in_use_imm,
    input  logic [DW-1:0] in_imm,
    output logic          alu_valid,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [CW-1:0] alu_code,
    input  logic [DW-1:0] alu_c,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic [15:0]   issue_cnt
);

    logic [AW-1:0] rd_q;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          wb_en;
    logic          hz_a;
    logic          hz_b;
    logic          accept;

    alu_regfile #(
        .DW  (DW),
        .NREG(NREG),
        .AW  (AW)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (in_rs1),
        .ra_data (rs1_data),
        .rb_addr (in_rs2),
        .rb_data (rs2_data),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
        .we      (wb_en),
        .waddr   (rd_q),
        .wdata   (alu_c)
    );

    // The op at the ALU writes rd_q on the coming edge; an incoming op
    // reading that register would otherwise see the pre-write value.
    assign wb_en = alu_valid && (rd_q != '0);
    assign hz_a  = wb_en && in_valid && (in_rs1 == rd_q);
    assign hz_b  = wb_en && in_valid && !in_use_imm && (in_rs2 == rd_q);

`ifdef ALU_FWD_EN
    assign in_ready = 1'b1;
    assign op_a = hz_a ? alu_c : rs1_data;
    assign op_b = in_use_imm ? in_imm : (hz_b ? alu_c : rs2_data);
`else
    // One-cycle stall: the writeback lands on this edge, so the retry
    // on the next edge reads the updated register file.
    assign in_ready = !(hz_a || hz_b);
    assign op_a = rs1_data;
    assign op_b = in_use_imm ? in_imm : rs2_data;
`endif

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_code  <= '0;
            rd_q      <= '0;
            issue_cnt <= '0;
        end else begin
            alu_valid <= accept;
            if (accept) begin
                alu_a     <= op_a;
                alu_b     <= op_b;
                alu_code  <= in_code;
                rd_q      <= in_rd;
                issue_cnt <= issue_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with a scoreboard of issued operands
// and a small sequential register model; includes a behavioural ALU.
module tb_alu_operand_stage;
    import alu_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_code;
    logic [2:0]    in_rd;
    logic [2:0]    in_rs1;
    logic [2:0]    in_rs2;
    logic          in_use_imm;
    logic [15:0]   in_imm;
    logic          alu_valid;
    logic [15:0]   alu_a;
    logic [15:0]   alu_b;
    logic [4:0]    alu_code;
    logic [15:0]   alu_c;
    logic [2:0]    dbg_addr;
    logic [15:0]   dbg_data;
    logic [15:0]   issue_cnt;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  code;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mrf [8];
    int          checks = 0;
    int          errors = 0;
    int          bubbles;

    always #10 clk = ~clk;

    alu_operand_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_use_imm(in_use_imm),
        .in_imm    (in_imm),
        .alu_valid (alu_valid),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_code  (alu_code),
        .alu_c     (alu_c),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .issue_cnt (issue_cnt)
    );

    function automatic logic [15:0] alu_f(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [4:0] c);
        case (c)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            default: return 16'h0;
        endcase
    endfunction

    assign alu_c = alu_f(alu_a, alu_b, alu_code);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    task automatic chk_dbg(input logic [2:0] addr, input logic [15:0] want);
        dbg_addr = addr;
        #1;
        chk($sformatf("dbg_r%0d", addr), {16'h0, dbg_data}, {16'h0, want});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mrf[i] = 16'h0;
    endtask

    // Scoreboard: each cycle the ALU sees a valid op, pop and compare.
    always @(negedge clk) begin
        if (alu_valid === 1'b1) begin
            exp_t e;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL sb_underflow got %0d want >0", sb.size());
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_alu_a", {16'h0, alu_a}, {16'h0, e.a});
                chk("sb_alu_b", {16'h0, alu_b}, {16'h0, e.b});
                chk("sb_alu_code", {27'h0, alu_code}, {27'h0, e.code});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input logic [4:0] code, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic ui, input logic [15:0] imm,
                         output int stalls);
        exp_t        e;
        logic [15:0] a;
        logic [15:0] b;
        logic        rdy;
        a = mrf[rs1];
        b = ui ? imm : mrf[rs2];
        e.a = a;
        e.b = b;
        e.code = code;
        sb.push_back(e);
        if (rd != 3'd0) mrf[rd] = alu_f(a, b, code);
        in_valid = 1'b1;
        in_code = code;
        in_rd = rd;
        in_rs1 = rs1;
        in_rs2 = rs2;
        in_use_imm = ui;
        in_imm = imm;
        stalls = 0;
        bubbles = 0;
        forever begin
            #1;
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) break;
            stalls++;
            if (alu_valid === 1'b0) bubbles++;
            if (stalls > 8) begin
                checks++;
                errors++;
                $error("FAIL issue_timeout got %0d stalls want <=8", stalls);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int   st;
        exp_t e;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_code = '0;
        in_rd = '0;
        in_rs1 = '0;
        in_rs2 = '0;
        in_use_imm = 1'b0;
        in_imm = '0;
        dbg_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_alu_valid", {31'h0, alu_valid}, 32'h0);
        chk("rst_issue_cnt", {16'h0, issue_cnt}, 32'h0);
        for (int i = 1; i < 8; i++) chk_dbg(3'(i), 16'h0);
        @(posedge clk);
        #1;

        // add r1 <- r0 + 5
        issue(ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, st);
        chk("add_valid", {31'h0, alu_valid}, 32'h1);
        chk("add_alu_a", {16'h0, alu_a}, 32'h0);
        chk("add_alu_b", {16'h0, alu_b}, 32'h5);
        idle();
        chk_dbg(3'd1, 16'h0005);
        chk("add_cnt", {16'h0, issue_cnt}, 32'h1);
        chk("idle_valid", {31'h0, alu_valid}, 32'h0);

        // Back-to-back dependent ops
        issue(ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0003, st);
        issue(ALU_ADD, 3'd2, 3'd1, 3'd1, 1'b0, 16'h0000, st);
`ifdef ALU_FWD_EN
        chk("hz_stalls", 32'(st), 32'd0);
        chk("hz_bubbles", 32'(bubbles), 32'd0);
`else
        chk("hz_stalls", 32'(st), 32'd1);
        chk("hz_bubbles", 32'(bubbles), 32'd1);
`endif
        chk("hz_valid", {31'h0, alu_valid}, 32'h1);
        idle();
        chk_dbg(3'd1, 16'h0003);
        chk_dbg(3'd2, 16'h0006);
        chk("hz_cnt", {16'h0, issue_cnt}, 32'h3);

        // rd = r0 never writes
        issue(ALU_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 16'h1234, st);
        idle();
        chk_dbg(3'd0, 16'h0000);

        // Undefined code: issued as-is, writeback of 0 still happens
        issue(ALU_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 16'h0009, st);
        issue(5'd31, 3'd4, 3'd4, 3'd0, 1'b1, 16'h0055, st);
        idle();
        chk_dbg(3'd4, mrf[4]);
        chk_dbg(3'd2, 16'h0006);

        // Reset while an op sits at the ALU; a second op is offered too
        issue(ALU_ADD, 3'd3, 3'd0, 3'd0, 1'b1, 16'h0007, st);
        in_valid = 1'b1;
        in_code = ALU_ADD;
        in_rd = 3'd5;
        in_rs1 = 3'd0;
        in_use_imm = 1'b1;
        in_imm = 16'h0009;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        model_reset();
        #1;
        chk("rr_valid", {31'h0, alu_valid}, 32'h0);
        chk("rr_cnt", {16'h0, issue_cnt}, 32'h0);
        chk("rr_ready", {31'h0, in_ready}, 32'h1);
        chk_dbg(3'd3, 16'h0000);
        chk_dbg(3'd5, 16'h0000);
        chk_dbg(3'd1, 16'h0000);
        @(posedge clk);
        #1;

        // Counter wrap over 65536 accepts
        in_valid = 1'b1;
        in_code = ALU_ADD;
        in_rd = 3'd0;
        in_rs1 = 3'd0;
        in_rs2 = 3'd0;
        in_use_imm = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            in_imm = 16'(i);
            e.a = 16'h0;
            e.b = 16'(i);
            e.code = ALU_ADD;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (i == 65534) chk("cnt_ffff", {16'h0, issue_cnt}, 32'hFFFF);
        end
        chk("cnt_wrap", {16'h0, issue_cnt}, 32'h0);
        idle();
        idle();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
